debug_sender: RTL
=================

# debug_sender

Debug-unit transmit stage, directly downstream of the debug controller. When the controller raises `send_flag`, the block serializes a fixed snapshot of processor state into bytes for the UART transmitter:

- an optional cycle count;
- the PC;
- every register-file word;
- the first `DM_WORDS` data-memory words.

It then pulses `send_done` so the controller can leave its send state.

## Interface
Parameters:
- `NBITS`, 32: width of every transmitted word; fixed 4 bytes, so only 32 is supported.
- `NREGS`, 32: number of register-file words sent.
- `RF_ADDR_LENGTH`, 5: register-file address width.
- `DM_WORDS`, 32: number of data-memory words sent, from address 0 upward.
- `DM_ADDR_LENGTH`, 32: data-memory address width.

Ports:
- `clk`  in  1  system clock; one clock domain.
- `reset`  in  1  asynchronous, active-high reset.
- `send_flag`  in  1  level from the controller; held high until `send_done` is seen.
- `tx_done`  in  1  one-cycle pulse from the UART TX when the current byte has finished.
- `pc_value`  in  NBITS  current PC.
- `rf_data`  in  NBITS  register-file debug read data; combinational from `rf_addr`.
- `dm_data`  in  NBITS  data-memory debug read data; combinational from `dm_addr`.
- `enable`  in  1  processor enable; drives the cycle counter.
- `cpu_reset`  in  1  processor reset from the controller; clears the cycle counter.
- `rf_addr`  out  RF_ADDR_LENGTH  register-file debug read address; registered.
- `dm_addr`  out  DM_ADDR_LENGTH  data-memory debug read address; registered.
- `tx_start`  out  1  one-cycle pulse starting a UART byte.
- `tx_data`  out  8  byte to transmit; registered and stable from the `tx_start` cycle until `tx_done`.
- `send_done`  out  1  one-cycle pulse when the last byte has completed.

## Operation
- Word sequence, index `w`:
  - `[CYCLES]` (only when compiled in);
  - `PC`;
  - `R0` .. `R(NREGS-1)`;
  - `M0` .. `M(DM_WORDS-1)`.
- `W` = `1+NREGS+DM_WORDS`, plus 1 when the cycle count is compiled in.
- Bytes within a word are sent big-endian: `[31:24]` first, `[7:0]` last.
- `rf_addr` and `dm_addr` are loaded in the same cycle `w` advances, so the read data is settled when LOAD samples it.
- States:
  - IDLE: on `send_flag`=1 → LOAD, with `w`=0 and addresses set for word 0.
  - LOAD: latch the selected source into `word_reg`; byte index `b`=0 → SEND.
  - SEND: `tx_data`=`word_reg[31-8b -: 8]`, `tx_start`=1 for exactly this cycle → WAIT.
  - WAIT: act only on `tx_done`:
    - if `b`<3: `b`++ → SEND;
    - else if `w`=`W`-1 → DONE;
    - else `w`++, update addresses → LOAD.
  - DONE: `send_done`=1 for this cycle only → HOLD.
  - HOLD: stay until `send_flag`=0 → IDLE. This prevents retransmission while the controller is still dropping its flag.
- `tx_done` outside WAIT is ignored, including a `tx_done` in the same cycle as `tx_start`.
- `send_flag` dropping mid-transfer is ignored; the full snapshot always completes.
- The `PC` word samples `pc_value` at its LOAD cycle. Sources are frozen because the controller holds `enable`=0 during the send.

## Timing
- Reset values: state IDLE; `tx_start`=0, `tx_data`=0, `send_done`=0, `rf_addr`=0, `dm_addr`=0; counter 0.
- Latency from `send_flag` rising to the first `tx_start`: 2 cycles (IDLE→LOAD→SEND).
- Byte-to-byte: `tx_done` at cycle t gives the next `tx_start` at t+1 within a word, or t+2 across a word boundary (via LOAD).
- `send_done` is asserted at the cycle after the final `tx_done`.
- Asserting `reset` mid-transfer aborts immediately: all outputs return to reset values and the remaining bytes are dropped.

## Configuration
- `DEBUG_SEND_CYCLES_EN` defined:
  - a 32-bit counter increments each `clk` with `enable`=1 and wraps from `FFFFFFFF` to 0;
  - it is cleared by `reset` or by `cpu_reset`=1, with clear taking priority over increment;
  - it is sent as word 0, giving `W`=`2+NREGS+DM_WORDS`.
- Undefined: no counter; `enable` and `cpu_reset` are ignored; `W`=`1+NREGS+DM_WORDS`.

## Test plan
- Macro off, defaults, `tx_done` returned 3 cycles after each `tx_start`, `pc_value`=`0x00000010`, `Rk`=k, `Mk`=`0x100+k`: expect exactly 260 `tx_start` pulses. First bytes are `00 00 00 10 00 00 00 00 00 00 00 01`; last four are `00 00 01 1F`. Then one `send_done` pulse.
- `send_flag` held high for 5 cycles after `send_done`: no further `tx_start`. Drop then re-raise `send_flag`: a second full 260-byte transfer.
- Spurious `tx_done` in IDLE and in the `tx_start` cycle: ignored, with no byte skipped. Check `tx_data` is unchanged between `tx_start` and `tx_done`.
- Assert `reset` after byte 37: `tx_start`, `send_done` and addresses are 0 next cycle, state is IDLE. A new `send_flag` restarts from the first PC byte.
- Macro on, `enable`=1 for 100 cycles, then 0, then `send_flag`: first word is `0x00000064` and 264 bytes are sent. Pulse `cpu_reset`, repeat: first word is `0x00000000`.
- Back-to-back `tx_done` (returned the cycle after each `tx_start`): inter-byte gap is 2 cycles within a word and 3 across words. Data order is unchanged.

Source files
------------

// File: rtl/debug_sender.sv
// Debug-unit transmit stage: serializes [cycles], PC, register file and data memory as
// big-endian bytes to the UART TX. Define DEBUG_SEND_CYCLES_EN to prepend the cycle count.
module debug_sender #(
    parameter int unsigned NBITS          = 32,
    parameter int unsigned NREGS          = 32,
    parameter int unsigned RF_ADDR_LENGTH = 5,
    parameter int unsigned DM_WORDS       = 32,
    parameter int unsigned DM_ADDR_LENGTH = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      send_flag,
    input  logic                      tx_done,
    input  logic [NBITS-1:0]          pc_value,
    input  logic [NBITS-1:0]          rf_data,
    input  logic [NBITS-1:0]          dm_data,
    input  logic                      enable,
    input  logic                      cpu_reset,
    output logic [RF_ADDR_LENGTH-1:0] rf_addr,
    output logic [DM_ADDR_LENGTH-1:0] dm_addr,
    output logic                      tx_start,
    output logic [7:0]                tx_data,
    output logic                      send_done
);

`ifdef DEBUG_SEND_CYCLES_EN
    localparam int unsigned CntWords = 1;
`else
    localparam int unsigned CntWords = 0;
`endif
    localparam int unsigned PcIdx    = CntWords;
    localparam int unsigned RfBase   = CntWords + 1;
    localparam int unsigned DmBase   = RfBase + NREGS;
    localparam int unsigned NumWords = DmBase + DM_WORDS;
    localparam int unsigned WIdxW    = $clog2(NumWords);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StSend,
        StWait,
        StDone,
        StHold
    } state_e;

    state_e                    state_q, state_d;
    logic [WIdxW-1:0]          w_q, w_d;
    logic [1:0]                b_q, b_d;
    logic [NBITS-1:0]          word_q, word_d;
    logic [RF_ADDR_LENGTH-1:0] rf_addr_q, rf_addr_d;
    logic [DM_ADDR_LENGTH-1:0] dm_addr_q, dm_addr_d;
    logic [31:0]               w_next;
    logic [NBITS-1:0]          src_word;

`ifdef DEBUG_SEND_CYCLES_EN
    logic [31:0] cycles_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycles_q <= '0;
        end else if (cpu_reset) begin
            cycles_q <= '0;
        end else if (enable) begin
            cycles_q <= cycles_q + 32'd1;
        end
    end
`else
    logic unused_ctrl;
    assign unused_ctrl = enable ^ cpu_reset;
`endif

    assign w_next = 32'(w_q) + 32'd1;

    always_comb begin
        src_word = dm_data;
        if (32'(w_q) == PcIdx) begin
            src_word = pc_value;
        end else if (32'(w_q) < DmBase) begin
            src_word = rf_data;
        end
`ifdef DEBUG_SEND_CYCLES_EN
        if (w_q == '0) begin
            src_word = NBITS'(cycles_q);
        end
`endif
    end

    // The word register shifts left after each byte so the outgoing byte is always its MSB.
    always_comb begin
        state_d   = state_q;
        w_d       = w_q;
        b_d       = b_q;
        word_d    = word_q;
        rf_addr_d = rf_addr_q;
        dm_addr_d = dm_addr_q;
        case (state_q)
            StIdle: begin
                if (send_flag) begin
                    state_d   = StLoad;
                    w_d       = '0;
                    rf_addr_d = '0;
                    dm_addr_d = '0;
                end
            end
            StLoad: begin
                word_d  = src_word;
                b_d     = 2'd0;
                state_d = StSend;
            end
            StSend: begin
                state_d = StWait;
            end
            StWait: begin
                if (tx_done) begin
                    if (b_q != 2'd3) begin
                        b_d     = b_q + 2'd1;
                        word_d  = word_q << 8;
                        state_d = StSend;
                    end else if (32'(w_q) == NumWords - 1) begin
                        state_d = StDone;
                    end else begin
                        // Addresses move with w so the read data settles before LOAD.
                        w_d = WIdxW'(w_next);
                        if (w_next >= RfBase && w_next < DmBase) begin
                            rf_addr_d = RF_ADDR_LENGTH'(w_next - RfBase);
                        end
                        if (w_next >= DmBase) begin
                            dm_addr_d = DM_ADDR_LENGTH'(w_next - DmBase);
                        end
                        state_d = StLoad;
                    end
                end
            end
            StDone: begin
                state_d = StHold;
            end
            StHold: begin
                if (!send_flag) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            w_q       <= '0;
            b_q       <= 2'd0;
            word_q    <= '0;
            rf_addr_q <= '0;
            dm_addr_q <= '0;
        end else begin
            state_q   <= state_d;
            w_q       <= w_d;
            b_q       <= b_d;
            word_q    <= word_d;
            rf_addr_q <= rf_addr_d;
            dm_addr_q <= dm_addr_d;
        end
    end

    assign tx_start  = (state_q == StSend);
    assign send_done = (state_q == StDone);
    assign tx_data   = word_q[NBITS-1 -: 8];
    assign rf_addr   = rf_addr_q;
    assign dm_addr   = dm_addr_q;

endmodule
